// File: rtl/mtpsa_arb_pkg.sv
// Shared types and constants for the MTPSA egress user arbiter.
package mtpsa_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int unsigned USER_ID_LSB  = 32;
  localparam int unsigned USER_ID_MSB  = 39;
  localparam int unsigned WEIGHT_WIDTH = 4;
  localparam int unsigned MAX_PORTS    = 8;

  // Tenant id for a port; wraps modulo 256
  function automatic logic [7:0] user_id(input int unsigned offset, input int unsigned port);
    return 8'(offset + port);
  endfunction

endpackage

// File: rtl/mtpsa_rr_picker.sv
// Combinational rotating-priority picker: first requester after last_grant wins.
module mtpsa_rr_picker
  import mtpsa_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant_oh_c,
  output logic [IDX_W-1:0]     grant_idx_c,
  output logic                 valid_c
);

  logic [IDX_W-1:0] cand;

  // Scan last_grant+1 .. last_grant+NUM_PORTS, so the previous winner comes last
  always_comb begin
    grant_oh_c  = '0;
    grant_idx_c = '0;
    valid_c     = 1'b0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_PORTS);
      if (!valid_c && req[cand]) begin
        valid_c     = 1'b1;
        grant_idx_c = cand;
        grant_oh_c  = NUM_PORTS'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/mtpsa_egress_user_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared egress pipeline; stamps user_id into tuser.
// Define MTPSA_ARB_WEIGHT_EN for weighted round-robin using s_axis_weight.
module mtpsa_egress_user_arbiter
  import mtpsa_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS          = 4,
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned USER_ID_OFFSET     = 0
) (
  input  logic                                      axis_aclk,
  input  logic                                      axis_rst,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                      s_axis_tready,
  input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
  input  logic [NUM_PORTS*4-1:0]                    s_axis_weight,
  output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  output logic [NUM_PORTS-1:0]                      grant_onehot
);

  localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned KEEP_W = C_AXIS_DATA_WIDTH / 8;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0]    grant_oh_q, grant_oh_d;
  logic [NUM_PORTS-1:0]    pick_oh_c;
  logic [IDX_W-1:0]        pick_idx_c;
  logic                    pick_valid_c;
  logic                    pkt_done_c;
  logic [C_AXIS_TUSER_WIDTH-1:0] sel_user_c;

  mtpsa_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req         (s_axis_tvalid),
    .last_grant  (last_grant_q),
    .grant_oh_c  (pick_oh_c),
    .grant_idx_c (pick_idx_c),
    .valid_c     (pick_valid_c)
  );

  assign pkt_done_c = (state_q == XFER) && s_axis_tvalid[grant_idx_q]
                      && m_axis_tready && s_axis_tlast[grant_idx_q];
  assign grant_onehot = grant_oh_q;

`ifdef MTPSA_ARB_WEIGHT_EN
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [WEIGHT_WIDTH-1:0] pick_weight_c;

  // Weight of the freshly picked port; zero behaves like one
  always_comb begin
    pick_weight_c = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (IDX_W'(p) == pick_idx_c) begin
        pick_weight_c = s_axis_weight[p*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end
`else
  logic unused_weight;
  assign unused_weight = ^s_axis_weight;
`endif

  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
`ifdef MTPSA_ARB_WEIGHT_EN
      credit_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
`ifdef MTPSA_ARB_WEIGHT_EN
      credit_q     <= credit_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
`ifdef MTPSA_ARB_WEIGHT_EN
    credit_d     = credit_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MTPSA_ARB_WEIGHT_EN
        if (credit_q != '0 && s_axis_tvalid[last_grant_q]) begin
          state_d     = XFER;
          grant_idx_d = last_grant_q;
          grant_oh_d  = NUM_PORTS'(1) << last_grant_q;
          credit_d    = credit_q - WEIGHT_WIDTH'(1);
        end else if (pick_valid_c) begin
          state_d     = XFER;
          grant_idx_d = pick_idx_c;
          grant_oh_d  = pick_oh_c;
          credit_d    = (pick_weight_c == '0) ? '0 : pick_weight_c - WEIGHT_WIDTH'(1);
        end
`else
        if (pick_valid_c) begin
          state_d     = XFER;
          grant_idx_d = pick_idx_c;
          grant_oh_d  = pick_oh_c;
        end
`endif
      end
      XFER: begin
        if (pkt_done_c) begin
          state_d      = IDLE;
          grant_oh_d   = '0;
          last_grant_d = grant_idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pass-through mux of the granted port with user_id overlay
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    sel_user_c    = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (IDX_W'(p) == grant_idx_q) begin
        m_axis_tdata = s_axis_tdata[p*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        m_axis_tkeep = s_axis_tkeep[p*KEEP_W +: KEEP_W];
        m_axis_tlast = s_axis_tlast[p];
        sel_user_c   = s_axis_tuser[p*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        sel_user_c[USER_ID_MSB:USER_ID_LSB] = user_id(USER_ID_OFFSET, p);
      end
    end
    m_axis_tuser = sel_user_c;
    if (state_q == XFER) begin
      m_axis_tvalid              = s_axis_tvalid[grant_idx_q];
      s_axis_tready[grant_idx_q] = m_axis_tready;
    end
  end

endmodule

// File: tb/tb_mtpsa_egress_user_arbiter.sv
// Self-checking bench for mtpsa_egress_user_arbiter against a packet-queue reference model.
module tb_mtpsa_egress_user_arbiter;

  localparam int N   = 4;
  localparam int W   = 256;
  localparam int KW  = W / 8;
  localparam int TU  = 128;
  localparam int OFS = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic [TU-1:0] user;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*W-1:0]    s_axis_tdata;
  logic [N*KW-1:0]   s_axis_tkeep;
  logic [N*TU-1:0]   s_axis_tuser;
  logic [N-1:0]      s_axis_tvalid;
  logic [N-1:0]      s_axis_tready;
  logic [N-1:0]      s_axis_tlast;
  logic [N*4-1:0]    s_axis_weight;
  logic [W-1:0]      m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [TU-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [N-1:0]      grant_onehot;

  mtpsa_egress_user_arbiter #(
    .NUM_PORTS(N), .C_AXIS_DATA_WIDTH(W), .C_AXIS_TUSER_WIDTH(TU), .USER_ID_OFFSET(OFS)
  ) dut (
    .axis_aclk(clk), .axis_rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_weight(s_axis_weight),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .grant_onehot(grant_onehot)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t q [N][$];
  bit    m_busy;
  int    m_g;
  int    m_last;
  int    pkt_cnt [N];

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_packet(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < W / 32; w++) b.data[w*32 +: 32] = $urandom();
      b.keep = $urandom();
      for (int w = 0; w < TU / 32; w++) b.user[w*32 +: 32] = $urandom();
      b.last = (i == len - 1);
      q[p].push_back(b);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < N; p++) s += q[p].size();
    return s;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_last = N - 1;
    for (int p = 0; p < N; p++) begin
      q[p].delete();
      pkt_cnt[p] = 0;
    end
  endtask

  // One clock: drive at negedge, compare before the next posedge, then advance the model
  task automatic step(input int vprob, input int rprob, input logic [N-1:0] hold_off);
    logic [N-1:0] v;
    logic [N-1:0] exp_oh;
    logic [N-1:0] exp_rdy;
    logic [TU-1:0] exp_user;
    beat_t hb;
    @(negedge clk);
    v = '0;
    for (int p = 0; p < N; p++) begin
      if (q[p].size() > 0) begin
        hb = q[p][0];
        v[p] = !hold_off[p] && ($urandom_range(0, 99) < vprob);
      end else begin
        hb = '{default: '0};
      end
      s_axis_tdata[p*W +: W]   = hb.data;
      s_axis_tkeep[p*KW +: KW] = hb.keep;
      s_axis_tuser[p*TU +: TU] = hb.user;
      s_axis_tlast[p]          = hb.last;
    end
    s_axis_tvalid = v;
    m_axis_tready = ($urandom_range(0, 99) < rprob);
    #1;
    if (!m_busy) begin
      check_eq("idle_grant", grant_onehot, '0);
      check_eq("idle_tvalid", m_axis_tvalid, 1'b0);
      check_eq("idle_tready", s_axis_tready, '0);
      if (|v) begin
        for (int k = 1; k <= N; k++) begin
          if (!m_busy && v[(m_last + k) % N]) begin
            m_g    = (m_last + k) % N;
            m_busy = 1'b1;
          end
        end
      end
    end else begin
      exp_oh = '0;
      exp_oh[m_g] = 1'b1;
      exp_rdy = '0;
      exp_rdy[m_g] = m_axis_tready;
      check_eq("grant", grant_onehot, exp_oh);
      check_eq("tvalid", m_axis_tvalid, v[m_g]);
      check_eq("tready", s_axis_tready, exp_rdy);
      if (v[m_g]) begin
        hb = q[m_g][0];
        exp_user = hb.user;
        exp_user[39:32] = 8'(OFS + m_g);
        check_eq("tdata", m_axis_tdata, hb.data);
        check_eq("tkeep", m_axis_tkeep, hb.keep);
        check_eq("tuser", m_axis_tuser, exp_user);
        check_eq("tlast", m_axis_tlast, hb.last);
        if (m_axis_tready) begin
          void'(q[m_g].pop_front());
          if (hb.last) begin
            m_busy = 1'b0;
            m_last = m_g;
            pkt_cnt[m_g]++;
          end
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int vprob, input int rprob, input int budget);
    int c = 0;
    while ((pending() > 0 || m_busy) && c < budget) begin
      step(vprob, rprob, '0);
      c++;
    end
    check_eq(tag, 256'(pending()), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_weight = '0;
    m_axis_tready = 1'b0;
    model_reset();

    // Reset holds every output at its idle value even with requests present
    @(negedge clk);
    s_axis_tvalid = '1;
    m_axis_tready = 1'b1;
    #1;
    check_eq("rst_grant", grant_onehot, '0);
    check_eq("rst_tvalid", m_axis_tvalid, 1'b0);
    check_eq("rst_tready", s_axis_tready, '0);
    @(negedge clk);
    s_axis_tvalid = '0;
    rst = 1'b0;

    // Ports 0 and 2 with one 3-beat packet each
    add_packet(0, 3);
    add_packet(2, 3);
    drain("drain_two", 100, 100, 20);

    // Four backlogged ports with 1-beat packets: equal share
    for (int p = 0; p < N; p++) pkt_cnt[p] = 0;
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < N; p++) add_packet(p, 1);
    drain("drain_fair", 100, 100, 60);
    for (int p = 0; p < N; p++) check_eq("fair_share", 256'(pkt_cnt[p]), 256'(4));

    // Downstream ready toggling every cycle during a 4-beat packet
    add_packet(0, 4);
    for (int i = 0; i < 20 && (pending() > 0 || m_busy); i++) step(100, (i % 2) ? 100 : 0, '0);
    check_eq("drain_toggle", 256'(pending()), '0);

    // Random traffic on all ports
    for (int p = 0; p < N; p++)
      for (int i = 0; i < 15; i++) add_packet(p, $urandom_range(1, 4));
    drain("drain_random", 70, 70, 3000);

    // Reset in the middle of a port 2 packet
    add_packet(2, 8);
    for (int i = 0; i < 3; i++) step(100, 100, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_tvalid", m_axis_tvalid, 1'b0);
    check_eq("midrst_grant", grant_onehot, '0);
    check_eq("midrst_tready", s_axis_tready, '0);
    model_reset();
    s_axis_tvalid = '0;
    @(negedge clk);
    rst = 1'b0;

    // After reset port 0 must win over port 2
    add_packet(0, 1);
    add_packet(2, 1);
    step(100, 100, '0);
    check_eq("post_rst_pick", 256'(m_g), 256'(0));
    drain("drain_post_rst", 100, 100, 20);

    // Granted port 1 stalls for 5 cycles while port 3 waits
    add_packet(1, 3);
    step(100, 100, '0);
    step(100, 100, '0);
    add_packet(3, 3);
    for (int i = 0; i < 5; i++) step(100, 100, 4'b0010);
    drain("drain_stall", 100, 100, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mtpsa_egress_user_arbiter.md
Name: mtpsa_egress_user_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single suEgress SDNet pipeline between NUM_PORTS per-tenant AXI-Stream queues.
- Sits in front of the egress wrapper.
- Grants one input at a time and holds the grant until that packet's tlast beat completes.
- Stamps the granted tenant's user_id into tuser[39:32] before the packet reaches the egress pipeline.

Parameters:
NUM_PORTS, 4, number of tenant input streams (2..8)
C_AXIS_DATA_WIDTH, 256, tdata width
C_AXIS_TUSER_WIDTH, 128, tuser width (MTPSA metadata format)
USER_ID_OFFSET, 0, user_id stamped for port p = USER_ID_OFFSET + p (8-bit, wraps mod 256)

Ports:
axis_aclk  in  1  clock for all logic
axis_rst  in  1  asynchronous active-high reset
s_axis_tdata  in  NUM_PORTS*C_AXIS_DATA_WIDTH  flattened; port p at [p*W +: W]
s_axis_tkeep  in  NUM_PORTS*C_AXIS_DATA_WIDTH/8  flattened keep
s_axis_tuser  in  NUM_PORTS*C_AXIS_TUSER_WIDTH  flattened tuser
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tready  out  NUM_PORTS  per-port ready
s_axis_tlast  in  NUM_PORTS  per-port last
s_axis_weight  in  NUM_PORTS*4  per-port packets-per-turn (used only with feature)
m_axis_tdata  out  C_AXIS_DATA_WIDTH  to egress pipeline
m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8
m_axis_tuser  out  C_AXIS_TUSER_WIDTH  tuser with [39:32] overwritten
m_axis_tvalid  out  1
m_axis_tready  in  1
m_axis_tlast  out  1
grant_onehot  out  NUM_PORTS  current grant, 0 when idle (status/debug)

Behaviour:
Reset:
- Asynchronous, active-high; axis_rst is the only reset.
- Reset state: state=IDLE, grant=0, last_grant=NUM_PORTS-1 (so port 0 wins first), credit=0.
- All s_axis_tready=0, m_axis_tvalid=0, grant_onehot=0.

FSM states: IDLE, XFER.

IDLE:
- If any s_axis_tvalid[p], the picker selects the first requester scanning last_grant+1, last_grant+2, … modulo NUM_PORTS.
- The selection is registered into grant; go to XFER next cycle.
- Nothing is forwarded in IDLE. One bubble cycle per packet; request-to-first-output-beat latency is 1 cycle.

XFER:
- Output path is a combinational mux of the granted port:
  - m_axis_tvalid = s_axis_tvalid[g]; s_axis_tready[g] = m_axis_tready; all other readies 0.
  - tdata, tkeep and tlast pass through unchanged.
  - m_axis_tuser = s_axis_tuser[g] with bits [39:32] replaced by (USER_ID_OFFSET+g)[7:0]; all other bits untouched.
- On a beat where tvalid&tready&tlast: last_grant<=g, grant<=0, state<=IDLE.
- A granted port dropping tvalid mid-packet is legal. Stay in XFER and wait; the grant is never revoked mid-packet.
- Single-beat packets take 2 cycles (IDLE+XFER).

Other rules:
- No input port changes the grant mid-packet.
- A simultaneous request from the currently granted port at IDLE competes normally; it has lowest priority without the feature.
- m_axis_tready low holds all signals stable (AXIS rule, because the path is pass-through).
- Reset mid-packet aborts immediately: outputs drop to reset values and the downstream packet is truncated. Upstream and downstream must also be reset.

Optional Feature:
Macro: MTPSA_ARB_WEIGHT_EN
- Defined: weighted round-robin.
  - On a new grant to p, credit<=max(weight[p],1)-1.
  - In IDLE, if credit>0 and s_axis_tvalid[last_grant], regrant last_grant and decrement credit.
  - Otherwise rotate normally.
  - A weight of 0 is treated as 1.
- Undefined: s_axis_weight is ignored and the credit register is not built. Plain RR, each grant lasts one packet.

Decomposition:
Package mtpsa_arb_pkg:
- state enum {IDLE, XFER}
- USER_ID_LSB=32, USER_ID_MSB=39
- WEIGHT_WIDTH=4
- MAX_PORTS=8

Sub-module mtpsa_rr_picker:
- Combinational rotating-priority picker.
- Inputs: req vector and last_grant index.
- Outputs: onehot grant and index, plus a valid flag.

Test Plan:
- Ports 0 and 2 each hold a 3-beat packet, reset released -> port 0 forwarded first with tuser[39:32]=0x00, one bubble, then port 2 with tuser[39:32]=0x02; other tuser bits bit-identical to input.
- All 4 ports continuously backlogged with 1-beat packets -> grant_onehot sequence 0001,0010,0100,1000,0001; each port gets 25% of packets.
- Port 1 mid-packet deasserts tvalid for 5 cycles while port 3 is valid -> grant stays 0010, port 3 tready=0 until port 1 tlast is accepted.
- m_axis_tready toggled 1/0 every cycle during a 4-beat packet -> all 4 beats delivered in order, no duplication or loss, tlast only on beat 4.
- Assert axis_rst mid-packet on port 2 -> same-cycle m_axis_tvalid=0, grant_onehot=0; after release, port 0 is arbitrated first.
- MTPSA_ARB_WEIGHT_EN, weights {p0=3,p1=1}, both backlogged -> packet order p0,p0,p0,p1,p0,p0,p0,p1; weight 0 behaves as 1.
